// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the RAM arbiter: FSM states, requester ids
// and the address legality check applied when a request is captured.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arbStateT;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } reqIdT;

    // Address is passed zero-extended to 64 bits so one helper serves any XLEN up to 64.
    function automatic logic addrErr(input logic [63:0] addr, input int wordAw);
        logic misaligned;
        logic outOfRange;
        misaligned = (addr[1:0] != 2'b00);
        outOfRange = ((addr >> (wordAw + 2)) != 64'd0);
        return misaligned | outOfRange;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way round-robin picker: on contention the port that did not win last
// time is chosen; a lone requester always wins.
module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic  ifReq,
    input  logic  dReq,
    input  reqIdT lastGrant,
    output reqIdT winner,
    output logic  anyReq
);

    always_comb begin
        anyReq = ifReq | dReq;
        winner = REQ_FETCH;
        if (ifReq && dReq) begin
            winner = (lastGrant == REQ_DATA) ? REQ_FETCH : REQ_DATA;
        end else if (dReq) begin
            winner = REQ_DATA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous-read RAM between the instruction-fetch
// port and the load/store port, one access every three cycles.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int WORD_AW = 10
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            ifReq,
    input  logic [XLEN-1:0] ifAddr,
    output logic            ifGnt,
    output logic            ifRvalid,
    output logic [XLEN-1:0] ifRdata,
    output logic            ifErr,

    input  logic            dReq,
    input  logic            dWe,
    input  logic [XLEN-1:0] dAddr,
    input  logic [XLEN-1:0] dWdata,
    output logic            dGnt,
    output logic            dRvalid,
    output logic [XLEN-1:0] dRdata,
    output logic            dErr,

    output logic [XLEN-1:0] ramAddress,
    output logic [XLEN-1:0] ramDataIn,
    output logic            ramWriteEnable,
    input  logic [XLEN-1:0] ramDataOut
);

    // Handshake: a requester raises req with its command stable and keeps it
    // until the one-cycle gnt; gnt only appears in IDLE. Exactly two cycles
    // after gnt the same port sees a one-cycle rvalid with rdata/err valid.
    arbStateT        state;
    arbStateT        nextState;
    reqIdT           lastGrant;
    reqIdT           capId;
    reqIdT           winner;
    logic            anyReq;
    logic            capture;
    logic            capWe;
    logic            capErr;
    logic            selWe;
    logic            selErr;
    logic [XLEN-1:0] selAddr;
    logic [XLEN-1:0] selWdata;
    logic [XLEN-1:0] respData;

    ram_arb_pick uPick (
        .ifReq     (ifReq),
        .dReq      (dReq),
        .lastGrant (lastGrant),
        .winner    (winner),
        .anyReq    (anyReq)
    );

    always_comb begin
        selWe    = 1'b0;
        selAddr  = ifAddr;
        selWdata = '0;
        if (winner == REQ_DATA) begin
            selWe    = dWe;
            selAddr  = dAddr;
            selWdata = dWdata;
        end
        selErr = addrErr(64'(selAddr), WORD_AW);
    end

    assign capture = (state == IDLE) && anyReq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = ACCESS;
            ACCESS:  nextState = RESPOND;
            RESPOND: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // RAM command registers load at the capture edge so they are valid for the
    // whole ACCESS cycle; address/data then hold until the next capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lastGrant      <= REQ_DATA;
            capId          <= REQ_FETCH;
            capWe          <= 1'b0;
            capErr         <= 1'b0;
            ramAddress     <= '0;
            ramDataIn      <= '0;
            ramWriteEnable <= 1'b0;
        end else if (capture) begin
            lastGrant      <= winner;
            capId          <= winner;
            capWe          <= selWe;
            capErr         <= selErr;
            ramAddress     <= XLEN'(selAddr[WORD_AW+1:2]);
            ramDataIn      <= selWdata;
            ramWriteEnable <= selWe & ~selErr;
        end else begin
            ramWriteEnable <= 1'b0;
        end
    end

    always_comb begin
        ifGnt    = 1'b0;
        dGnt     = 1'b0;
        ifRvalid = 1'b0;
        dRvalid  = 1'b0;
        ifRdata  = '0;
        dRdata   = '0;
        ifErr    = 1'b0;
        dErr     = 1'b0;
        respData = (capWe | capErr) ? '0 : ramDataOut;
        case (state)
            IDLE: begin
                // Gated by reset_n so no grant leaks out while reset is held.
                if (reset_n && anyReq) begin
                    ifGnt = (winner == REQ_FETCH);
                    dGnt  = (winner == REQ_DATA);
                end
            end
            RESPOND: begin
                if (capId == REQ_FETCH) begin
                    ifRvalid = 1'b1;
                    ifRdata  = respData;
                    ifErr    = capErr;
                end else begin
                    dRvalid  = 1'b1;
                    dRdata   = respData;
                    dErr     = capErr;
                end
            end
            default: ;
        endcase
    end

    gntOnlyInIdle: assert property (@(posedge clk) disable iff (!reset_n)
        (ifGnt || dGnt) |-> (state == IDLE));
    singleGnt: assert property (@(posedge clk) disable iff (!reset_n)
        !(ifGnt && dGnt));
    writeOnlyInAccess: assert property (@(posedge clk) disable iff (!reset_n)
        ramWriteEnable |-> (state == ACCESS));

endmodule
